// File: rtl/snake_step_if.sv
`default_nettype none
// ============================================================================
// Module   : snake_step_if
// Purpose  : Phase req/ack handshake between the step scheduler and datapath.
// Revision : 1.0
// ============================================================================
interface snake_step_if;
  logic       step_req;
  logic [1:0] step_op;
  logic       step_ack;
  logic       collide;

  modport master (
    output step_req,
    output step_op,
    input  step_ack,
    input  collide
  );

  modport slave (
    input  step_req,
    input  step_op,
    output step_ack,
    output collide
  );
endinterface
`default_nettype wire

// File: rtl/snake_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : snake_step_scheduler
// Purpose  : Frame tick / step divider driving ERASE-MOVE-DRAW-CHECK phases.
// Revision : 1.0
// ============================================================================
module snake_step_scheduler #(
  parameter logic [19:0] TICK_RELOAD     = 20'hFFFFF,
  parameter int          FRAMES_PER_STEP = 16
) (
  input  wire logic       clk,
  input  wire logic       resetn,
  input  wire logic       enable,
  input  wire logic [1:0] speed,
  snake_step_if.master    hs,
  output logic            frame_tick,
  output logic [3:0]      frame_cnt,
  output logic            busy,
  output logic            overrun,
  output logic            game_over
);

  localparam logic [4:0] C_FPS = 5'(FRAMES_PER_STEP);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ERASE = 3'd1,
    S_MOVE  = 3'd2,
    S_DRAW  = 3'd3,
    S_CHECK = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t      r_state;
  logic [19:0] r_tick_cnt;
  logic        r_step_due;
  logic        r_req;
  logic [1:0]  r_op;

  logic [4:0]  w_shift;
  logic [4:0]  w_thr;
  logic        w_wrap;

  // ">=" rather than "==" so a speed increase mid-step wraps on the next tick
  always_comb begin
    w_shift = C_FPS >> speed;
    w_thr   = (w_shift == 5'd0) ? 5'd1 : w_shift;
    w_wrap  = ({1'b0, frame_cnt} >= (w_thr - 5'd1));
  end

  assign hs.step_req = r_req;
  assign hs.step_op  = r_op;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tick_cnt <= TICK_RELOAD;
      frame_tick <= 1'b0;
    end else if (enable) begin
      if (r_tick_cnt == 20'd0) begin
        r_tick_cnt <= TICK_RELOAD;
        frame_tick <= 1'b1;
      end else begin
        r_tick_cnt <= r_tick_cnt - 20'd1;
        frame_tick <= 1'b0;
      end
    end else begin
      frame_tick <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_cnt  <= 4'd0;
      r_step_due <= 1'b0;
    end else begin
      r_step_due <= 1'b0;
      if (frame_tick && enable) begin
        if (w_wrap) begin
          frame_cnt  <= 4'd0;
          r_step_due <= 1'b1;
        end else begin
          frame_cnt  <= frame_cnt + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_req     <= 1'b0;
      r_op      <= 2'd0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      overrun <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_step_due) begin
            r_state <= S_ERASE;
            r_req   <= 1'b1;
            r_op    <= 2'd0;
            busy    <= 1'b1;
          end
        end
        S_ERASE, S_MOVE, S_DRAW, S_CHECK: begin
          if (r_step_due) begin
            overrun <= 1'b1;
          end
          // Each accepted phase leaves req low for one cycle before the next rises
          if (r_req && hs.step_ack) begin
            r_req <= 1'b0;
            if (r_state == S_CHECK) begin
              busy <= 1'b0;
              r_op <= 2'd0;
              if (hs.collide) begin
                r_state   <= S_HALT;
                game_over <= 1'b1;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_state <= state_t'(r_state + 3'd1);
              r_op    <= r_op + 2'd1;
            end
          end else if (!r_req) begin
            r_req <= 1'b1;
          end
        end
        default: begin
          r_state <= S_HALT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
